// File: rtl/imem_load_arbiter.sv
// Shares a single-port instruction memory between a boot loader word stream and the core fetch stage.
// Optional macro IMEM_RELOAD_EN: loader activity while running restarts the load sequence.
module imem_load_arbiter #(
    parameter int WIDTH1    = 32,
    parameter int MEM_SIZE  = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WIDTH1-1:0] ld_data,
    input  logic              ld_last,
    input  logic              fetch_req,
    input  logic [WIDTH1-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [WIDTH1-1:0] fetch_data,
    output logic              fetch_err,
    output logic [WIDTH1-1:0] mem_addr,
    output logic              mem_wr,
    output logic [WIDTH1-1:0] mem_wdata,
    input  logic [WIDTH1-1:0] mem_rdata,
    output logic              cpu_run,
    output logic [WIDTH1-1:0] load_count,
    output logic              load_ovf
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [WIDTH1-1:0] BASE  = WIDTH1'(BASE_ADDR);
    localparam logic [WIDTH1-1:0] DEPTH = WIDTH1'(MEM_SIZE);

    state_t            state;
    state_t            state_next;
    logic              handshake;
    logic              full;
    logic              reload;
    logic              fetch_take;
    logic              fetch_bad;
    logic [WIDTH1-1:0] word_index;

    assign full       = (load_count == DEPTH);
    assign handshake  = ld_valid & ld_ready;
    assign word_index = (fetch_addr - BASE) >> 2;
    assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || (word_index >= DEPTH);
    assign fetch_take = (state == RUN) && fetch_req && !reload;

    // Ownership of the memory port follows the state alone; ld_ready is masked while reset is held
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        cpu_run    = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        mem_addr   = BASE + {load_count[WIDTH1-3:0], 2'b00};
        reload     = 1'b0;
        case (state)
            IDLE, LOAD: begin
                ld_ready = reset;
                if (ld_valid && reset) begin
                    mem_wr     = !full;
                    mem_wdata  = full ? '0 : ld_data;
                    state_next = ld_last ? RUN : LOAD;
                end
            end
            RUN: begin
                cpu_run  = 1'b1;
                mem_addr = fetch_addr;
`ifdef IMEM_RELOAD_EN
                if (ld_valid) begin
                    reload     = 1'b1;
                    state_next = LOAD;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            load_count  <= '0;
            load_ovf    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_data  <= '0;
        end else begin
            state       <= state_next;
            fetch_valid <= fetch_take;
            fetch_err   <= fetch_take && fetch_bad;
            fetch_data  <= (fetch_take && !fetch_bad) ? mem_rdata : '0;
            // Words past the end are swallowed so the loader can finish its stream
            if (reload) begin
                load_count <= '0;
                load_ovf   <= 1'b0;
            end else if (handshake) begin
                if (full) begin
                    load_ovf <= 1'b1;
                end else begin
                    load_count <= load_count + WIDTH1'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter: directed load/fetch scenarios plus randomized rounds
// checked against a word-level model of the loaded image.
module tb_imem_load_arbiter;

    localparam int W    = 32;
    localparam int MS   = 8;
    localparam int BASE = 0;
`ifdef IMEM_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [W-1:0]  ld_data = '0;
    logic          ld_last = 1'b0;
    logic          fetch_req = 1'b0;
    logic [W-1:0]  fetch_addr = '0;
    logic          fetch_valid;
    logic [W-1:0]  fetch_data;
    logic          fetch_err;
    logic [W-1:0]  mem_addr;
    logic          mem_wr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          cpu_run;
    logic [W-1:0]  load_count;
    logic          load_ovf;

    logic [W-1:0]  tb_mem [MS] = '{default: '0};
    logic [W-1:0]  tb_index;

    int            n_checks = 0;
    int            n_fail = 0;

    bit            m_run;
    int            m_count;
    bit            m_ovf;
    bit            e_fv;
    bit            e_fe;
    logic [W-1:0]  e_fd;
    logic [W-1:0]  exp_mem [MS] = '{default: '0};

    imem_load_arbiter #(.WIDTH1(W), .MEM_SIZE(MS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_run(cpu_run), .load_count(load_count), .load_ovf(load_ovf)
    );

    always #5 clk = ~clk;

    // Memory stand-in: combinational read, write on the strobe at the clock edge
    assign tb_index  = (mem_addr - W'(BASE)) >> 2;
    assign mem_rdata = (tb_index < W'(MS)) ? tb_mem[tb_index[2:0]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_wr && tb_index < W'(MS)) tb_mem[tb_index[2:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: verify last edge's results, drive inputs, verify the combinational view, advance the model
    task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit last,
                                 input bit fr, input logic [W-1:0] fa);
        bit           hs;
        bit           wr;
        bit           bad;
        logic [W-1:0] off;
        @(negedge clk);
        checkOutput("fetch_valid", W'(fetch_valid), W'(e_fv));
        checkOutput("fetch_err", W'(fetch_err), W'(e_fe));
        if (e_fv) checkOutput("fetch_data", fetch_data, e_fd);
        checkOutput("load_count", load_count, W'(m_count));
        checkOutput("load_ovf", W'(load_ovf), W'(m_ovf));
        ld_valid   = v;
        ld_data    = d;
        ld_last    = last;
        fetch_req  = fr;
        fetch_addr = fa;
        #1;
        hs = v && !m_run;
        wr = hs && (m_count < MS);
        checkOutput("ld_ready", W'(ld_ready), W'(!m_run));
        checkOutput("cpu_run", W'(cpu_run), W'(m_run));
        checkOutput("mem_wr", W'(mem_wr), W'(wr));
        checkOutput("mem_addr", mem_addr, m_run ? fa : W'(BASE + 4 * m_count));
        if (wr) checkOutput("mem_wdata", mem_wdata, d);
        e_fv = 1'b0;
        e_fe = 1'b0;
        e_fd = '0;
        if (m_run && v && RELOAD) begin
            m_run   = 1'b0;
            m_count = 0;
            m_ovf   = 1'b0;
        end else begin
            if (m_run && fr) begin
                off  = fa - W'(BASE);
                bad  = (fa[1:0] != 2'b00) || ((off >> 2) >= W'(MS));
                e_fv = 1'b1;
                e_fe = bad;
                e_fd = bad ? '0 : exp_mem[int'(off >> 2)];
            end
            if (hs) begin
                if (wr) begin
                    exp_mem[m_count] = d;
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
                if (last) m_run = 1'b1;
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b0;
        ld_valid  = 1'b0;
        fetch_req = 1'b0;
        #1;
        checkOutput("rst_ld_ready", W'(ld_ready), '0);
        checkOutput("rst_mem_wr", W'(mem_wr), '0);
        checkOutput("rst_cpu_run", W'(cpu_run), '0);
        checkOutput("rst_fetch_valid", W'(fetch_valid), '0);
        checkOutput("rst_fetch_err", W'(fetch_err), '0);
        checkOutput("rst_fetch_data", fetch_data, '0);
        checkOutput("rst_load_count", load_count, '0);
        checkOutput("rst_load_ovf", W'(load_ovf), '0);
        checkOutput("rst_mem_addr", mem_addr, W'(BASE));
        checkOutput("rst_mem_wdata", mem_wdata, '0);
        m_run   = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        e_fv    = 1'b0;
        e_fe    = 1'b0;
        e_fd    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic fetchCycle(input logic [W-1:0] fa);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, fa);
    endtask

    // Random load: optional idle gaps carrying stray fetch requests that must be ignored
    task automatic randomLoad(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0)
                applyStimulus(1'b0, W'($urandom), 1'b0, 1'($urandom), W'($urandom_range(0, MS - 1) * 4));
            applyStimulus(1'b1, W'($urandom), (i == n - 1), 1'($urandom), W'($urandom_range(0, MS - 1) * 4));
        end
    endtask

    task automatic randomFetch(input int n);
        logic [W-1:0] fa;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 5))
                0:       fa = W'($urandom_range(0, MS * 4 - 1)) | 32'h1;
                1:       fa = W'($urandom_range(MS, MS + 16) * 4);
                2:       fa = W'($urandom);
                default: fa = W'($urandom_range(0, MS - 1) * 4);
            endcase
            applyStimulus(1'b0, '0, 1'b0, ($urandom_range(0, 3) != 0), fa);
        end
    endtask

    initial begin
        doReset();

        // Five-word image with a gap, then fetches including back-to-back and faulting addresses
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'hA000_0000 + W'(i), (i == 4), 1'b0, '0);
            if (i == 1) idleCycle();
        end
        idleCycle();
        fetchCycle(32'd8);
        fetchCycle(32'd0);
        fetchCycle(32'd4);
        fetchCycle(32'd16);
        fetchCycle(32'd6);
        fetchCycle(32'd4096);
        idleCycle();
        idleCycle();

        // Loader activity while running, with a fetch pending
        applyStimulus(1'b1, 32'hB000_0000, 1'b0, 1'b1, 32'd12);
        applyStimulus(1'b1, 32'hB000_0000, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'hB000_0001, 1'b1, 1'b1, 32'd4);
        idleCycle();
        fetchCycle(32'd0);
        fetchCycle(32'd4);
        fetchCycle(32'd12);
        idleCycle();

        // Overflow: more words than the memory holds
        doReset();
        for (int i = 0; i < MS + 2; i++)
            applyStimulus(1'b1, 32'hC000_0000 + W'(i), (i == MS + 1), 1'b0, '0);
        idleCycle();
        fetchCycle(W'((MS - 1) * 4));
        fetchCycle(W'(MS * 4));
        idleCycle();

        // Reset in the middle of a load, then a short reload from the base
        doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'hD000_0000 + W'(i), 1'b0, 1'b0, '0);
        doReset();
        applyStimulus(1'b1, 32'hE000_0000, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'hE000_0001, 1'b1, 1'b0, '0);
        idleCycle();
        fetchCycle(32'd0);
        fetchCycle(32'd4);
        fetchCycle(32'd8);
        fetchCycle(32'd20);
        idleCycle();

        for (int r = 0; r < 6; r++) begin
            doReset();
            randomLoad($urandom_range(1, MS + 3));
            randomFetch(12);
            idleCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Sequences and shares the single-port instruction memory between a boot loader word stream and the core's fetch stage.
- After reset, holds the core and streams loader words into consecutive word addresses. It then releases the core and serves fetches with a registered one-cycle response.
- Sits between the testbench/boot source, the PC/fetch logic and the instruction memory (combinational read, level-sensitive write).

Parameters:
- WIDTH1, 32, data and address width in bits
- MEM_SIZE, 1024, memory depth in words
- BASE_ADDR, 0, byte address of the first loaded word; must be word-aligned

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  loader word available
- ld_ready  out  1  arbiter accepts the loader word this cycle
- ld_data  in  WIDTH1  instruction word to write
- ld_last  in  1  marks the final word of the image
- fetch_req  in  1  core requests an instruction
- fetch_addr  in  WIDTH1  byte address of the requested instruction
- fetch_valid  out  1  fetch_data is valid (one cycle after the accepted request)
- fetch_data  out  WIDTH1  registered instruction word
- fetch_err  out  1  accompanies fetch_valid when the request was misaligned or out of range
- mem_addr  out  WIDTH1  byte address driven to the memory
- mem_wr  out  1  memory write strobe
- mem_wdata  out  WIDTH1  memory write data
- mem_rdata  in  WIDTH1  memory read data (combinational)
- cpu_run  out  1  core may advance its PC
- load_count  out  WIDTH1  number of words written in the current load
- load_ovf  out  1  sticky: loader tried to write past MEM_SIZE words

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0 except mem_addr=BASE_ADDR.
  - load_count=0, load_ovf=0.
  - Any in-flight fetch response is dropped.
- States: IDLE, LOAD, RUN.
- IDLE:
  - ld_ready=1, cpu_run=0.
  - ld_valid=1 writes the word, then → LOAD. If ld_last=1 on that word, → RUN directly.
- LOAD:
  - ld_ready=1, cpu_run=0.
  - A write happens on every cycle with ld_valid & ld_ready:
    - mem_wr=1 combinationally in that cycle;
    - mem_addr = BASE_ADDR + 4*load_count;
    - mem_wdata = ld_data;
    - load_count increments on the following edge.
  - ld_valid & ld_last: write the word, → RUN next cycle.
  - mem_wr=0 whenever no handshake occurs.
- Overflow: a handshake with load_count == MEM_SIZE gives no write (mem_wr=0). The word is still consumed (ld_ready=1), load_ovf sets, and load_count saturates at MEM_SIZE.
- RUN:
  - cpu_run=1, ld_ready=0, mem_wr is never asserted.
  - mem_addr = fetch_addr combinationally.
  - fetch_req=1 at edge N: at edge N fetch_data <= mem_rdata and fetch_valid <= 1, so both are visible during cycle N+1. Latency is 1; back-to-back requests are allowed every cycle.
  - fetch_valid=0 in any cycle following no request.
  - fetch_err=1 with fetch_valid if fetch_addr[1:0] != 0 or (fetch_addr - BASE_ADDR) >> 2 >= MEM_SIZE; fetch_data=0 in that case.
- fetch_req outside RUN: ignored, no response.
- The loader and the core never drive the memory in the same cycle. Ownership is purely state-based; there is no priority logic in IDLE/LOAD.
- Address arithmetic is WIDTH1-bit unsigned, and wrap-around is not checked beyond the range test.
- Reset mid-load: the memory contents written so far remain, the counter restarts at 0, and the next load overwrites from BASE_ADDR.

Optional Feature:
- Macro IMEM_RELOAD_EN.
- Defined: in RUN, ld_valid=1 starts a reload.
  - Next edge: cpu_run=0, the pending fetch response is suppressed (fetch_valid=0), load_count=0, load_ovf cleared, → LOAD.
  - That first word is not consumed (ld_ready=0 in RUN); it is written on the first LOAD cycle.
- Undefined: ld_valid in RUN is ignored and ld_ready stays 0 until reset.

Test Plan:
- Load 5 words A0..A4 with BASE_ADDR=0, ld_last on A4 → mem_wr pulses at addresses 0,4,8,12,16; load_count=5; cpu_run=1 the cycle after A4.
- Then fetch_req with fetch_addr=8 → next cycle fetch_valid=1, fetch_data=A2, fetch_err=0. Back-to-back fetches of 0,4,16 → A0,A4? no: A0,A1,A4 on consecutive cycles.
- Fetch_addr=6 and fetch_addr=4096 (MEM_SIZE=1024) → fetch_valid=1, fetch_err=1, fetch_data=0.
- MEM_SIZE=4, stream 6 words with ld_last on the 6th → 4 writes only, load_ovf=1, load_count=4, ld_ready stays 1, then RUN.
- Drop reset low after 3 of 8 words → all outputs 0 immediately; restart load of 2 words → writes at 0,4, load_count=2.
- With IMEM_RELOAD_EN, assert ld_valid in RUN with a fetch pending → fetch_valid=0 next cycle, cpu_run=0, new words written from BASE_ADDR. Without the macro → ld_ready=0, no writes, fetches unaffected.
